// File: rtl/tag_array_ctrl.sv
// tag_array_ctrl: sequencer and arbiter for the L1 tag SRAM array (WAYS ways x SETS sets).
//
// After reset the array is swept to zero, one set per cycle. The single read port is then
// shared round-robin between the pipeline lookup and the coherence probe. The write port
// serves the refill/update requester.
//
// A write to the set being read in the same cycle is forwarded into the read response. The
// array itself returns the old data on a same-address collision, so this forwarding is needed.
//
// Ports:
//   clock, reset                  clock (rising edge), asynchronous active-low reset
//   lk_valid/lk_ready/lk_set      pipeline lookup request
//   pb_valid/pb_ready/pb_set      coherence probe request
//   rsp_valid/rsp_src/rsp_data    read response, one cycle after acceptance (src 1 = probe)
//   wr_valid/wr_ready/wr_set/
//   wr_wayOH/wr_data              write request; wr_data goes to every selected way
//   init_done                     initialisation sweep complete
//   arr_r_addr/arr_r_data         array read port (data valid one cycle after address)
//   arr_w_en/arr_w_addr/
//   arr_w_data/arr_w_maskOH       array write port
module tag_array_ctrl #(
    parameter int unsigned SETS  = 128,
    parameter int unsigned WAYS  = 8,
    parameter int unsigned TAG_W = 20,
    parameter int unsigned IDX_W = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    lk_valid,
    output logic                    lk_ready,
    input  logic [IDX_W-1:0]        lk_set,
    input  logic                    pb_valid,
    output logic                    pb_ready,
    input  logic [IDX_W-1:0]        pb_set,
    output logic                    rsp_valid,
    output logic                    rsp_src,
    output logic [WAYS*TAG_W-1:0]   rsp_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [IDX_W-1:0]        wr_set,
    input  logic [WAYS-1:0]         wr_wayOH,
    input  logic [TAG_W-1:0]        wr_data,
    output logic                    init_done,
    output logic [IDX_W-1:0]        arr_r_addr,
    input  logic [WAYS*TAG_W-1:0]   arr_r_data,
    output logic                    arr_w_en,
    output logic [IDX_W-1:0]        arr_w_addr,
    output logic [WAYS*TAG_W-1:0]   arr_w_data,
    output logic [WAYS-1:0]         arr_w_maskOH
);

    localparam logic [IDX_W-1:0] LastSet = IDX_W'(SETS - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;        // 0: lookup wins next contention, 1: probe
    logic             rsp_valid_q, rsp_src_q;
    logic             byp_q;
    logic [WAYS-1:0]  byp_mask_q;
    logic [TAG_W-1:0] byp_data_q;

    logic             run;
    logic             gnt_lk, gnt_pb, rd_fire, wr_fire, byp_hit;
    logic [IDX_W-1:0] rd_set;

    // Sweep sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LastSet) begin
                state_d = StRun;
                cnt_d   = '0;
            end
        end
    end

    assign run       = (state_q == StRun);
    assign init_done = run;

    // Round-robin read arbitration; the pointer only flips on a contended grant.
    assign gnt_lk     = run & lk_valid & (~pb_valid | ~rr_q);
    assign gnt_pb     = run & pb_valid & (~lk_valid | rr_q);
    assign lk_ready   = gnt_lk;
    assign pb_ready   = gnt_pb;
    assign rd_fire    = gnt_lk | gnt_pb;
    assign rd_set     = gnt_pb ? pb_set : lk_set;
    assign arr_r_addr = rd_set;
    assign rr_d       = (run & lk_valid & pb_valid) ? ~rr_q : rr_q;

    assign wr_ready = run;
    assign wr_fire  = run & wr_valid;
    assign byp_hit  = rd_fire & wr_fire & (wr_set == rd_set);

    // Write port: sweep writes zeros to all ways; in RUN it follows the write requester.
    // Gating with reset keeps the port quiet while reset is held low.
    always_comb begin
        arr_w_en     = 1'b0;
        arr_w_addr   = cnt_q;
        arr_w_maskOH = '1;
        arr_w_data   = '0;
        if (!run) begin
            arr_w_en = reset;
        end else begin
            arr_w_en     = wr_fire;
            arr_w_addr   = wr_set;
            arr_w_maskOH = wr_wayOH;
            arr_w_data   = {WAYS{wr_data}};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            byp_q       <= 1'b0;
            byp_mask_q  <= '0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rd_fire;
            rsp_src_q   <= rd_fire ? gnt_pb : rsp_src_q;
            byp_q       <= byp_hit;
            if (byp_hit) begin
                byp_mask_q <= wr_wayOH;
                byp_data_q <= wr_data;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_src   = rsp_src_q;

    // Merge forwarded write lanes over the (stale) array data; zero when idle.
    always_comb begin
        rsp_data = '0;
        if (rsp_valid_q) begin
            for (int i = 0; i < int'(WAYS); i++) begin
                rsp_data[i*TAG_W +: TAG_W] = (byp_q && byp_mask_q[i]) ? byp_data_q
                                                                     : arr_r_data[i*TAG_W +: TAG_W];
            end
        end
    end

endmodule

// File: tb/tb_tag_array_ctrl.sv
module tb_tag_array_ctrl;

    localparam int SETS  = 128;
    localparam int WAYS  = 8;
    localparam int TAG_W = 20;
    localparam int IDX_W = 7;
    localparam int DW    = WAYS * TAG_W;

    logic              clock, reset;
    logic              lk_valid, lk_ready, pb_valid, pb_ready;
    logic [IDX_W-1:0]  lk_set, pb_set, wr_set;
    logic              rsp_valid, rsp_src;
    logic [DW-1:0]     rsp_data;
    logic              wr_valid, wr_ready;
    logic [WAYS-1:0]   wr_wayOH;
    logic [TAG_W-1:0]  wr_data;
    logic              init_done;
    logic [IDX_W-1:0]  arr_r_addr, arr_w_addr;
    logic [DW-1:0]     arr_r_data, arr_w_data;
    logic              arr_w_en;
    logic [WAYS-1:0]   arr_w_maskOH;

    tag_array_ctrl #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_set(lk_set),
        .pb_valid(pb_valid), .pb_ready(pb_ready), .pb_set(pb_set),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_data(rsp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_set(wr_set),
        .wr_wayOH(wr_wayOH), .wr_data(wr_data),
        .init_done(init_done),
        .arr_r_addr(arr_r_addr), .arr_r_data(arr_r_data),
        .arr_w_en(arr_w_en), .arr_w_addr(arr_w_addr),
        .arr_w_data(arr_w_data), .arr_w_maskOH(arr_w_maskOH)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Two-port SRAM: registered read returning old data on same-address collision.
    logic [DW-1:0] mem [SETS];
    logic          do_preload = 1'b0;
    int            wr_count = 0;

    always @(posedge clock) begin
        arr_r_data <= mem[arr_r_addr];
        if (do_preload) begin
            for (int s = 0; s < SETS; s++) mem[s] <= {5{32'hA5A5_5A5A}} ^ DW'(s + 1);
        end else if (arr_w_en) begin
            wr_count <= wr_count + 1;
            for (int w = 0; w < WAYS; w++)
                if (arr_w_maskOH[w]) mem[arr_w_addr][w*TAG_W +: TAG_W] <= arr_w_data[w*TAG_W +: TAG_W];
        end
    end

    // Reference model: tag contents per set/way and the round-robin owner.
    logic [TAG_W-1:0] ref_mem [SETS][WAYS];
    logic             rr_probe = 1'b0;
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_set(input int s);
        logic [DW-1:0] v;
        for (int w = 0; w < WAYS; w++) v[w*TAG_W +: TAG_W] = ref_mem[s][w];
        return v;
    endfunction

    // One sweep cycle per iteration; called at posedge+1, returns at the next posedge+1.
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            #2;
            chk("sweep_wen", DW'(arr_w_en), DW'(1));
            chk("sweep_addr", DW'(arr_w_addr), DW'(i));
            chk("sweep_mask", DW'(arr_w_maskOH), DW'(8'hFF));
            chk("sweep_data", arr_w_data, '0);
            chk("sweep_done", DW'(init_done), DW'(0));
            chk("sweep_rdy", DW'({lk_ready, pb_ready, wr_ready}), DW'(0));
            @(posedge clock); #1;
        end
    endtask

    // One RUN cycle with the current inputs, checked against the model.
    task automatic step();
        logic             g_lk, g_pb;
        logic [IDX_W-1:0] rs;
        logic [DW-1:0]    exp_rd, exp_wd;
        #2;
        if (lk_valid && pb_valid) begin
            g_pb = rr_probe;
            g_lk = !rr_probe;
        end else begin
            g_lk = lk_valid;
            g_pb = pb_valid;
        end
        chk("lk_ready", DW'(lk_ready), DW'(g_lk));
        chk("pb_ready", DW'(pb_ready), DW'(g_pb));
        chk("wr_ready", DW'(wr_ready), DW'(1));
        chk("w_en", DW'(arr_w_en), DW'(wr_valid));
        if (wr_valid) begin
            for (int w = 0; w < WAYS; w++) exp_wd[w*TAG_W +: TAG_W] = wr_data;
            chk("w_addr", DW'(arr_w_addr), DW'(wr_set));
            chk("w_mask", DW'(arr_w_maskOH), DW'(wr_wayOH));
            chk("w_data", arr_w_data, exp_wd);
            for (int w = 0; w < WAYS; w++) if (wr_wayOH[w]) ref_mem[wr_set][w] = wr_data;
        end
        rs = g_pb ? pb_set : lk_set;
        exp_rd = pack_set(int'(rs));
        @(posedge clock); #1;
        chk("rsp_valid", DW'(rsp_valid), DW'(g_lk | g_pb));
        if (g_lk || g_pb) begin
            chk("rsp_src", DW'(rsp_src), DW'(g_pb));
            chk("rsp_data", rsp_data, exp_rd);
        end
        if (lk_valid && pb_valid) rr_probe = g_lk;
    endtask

    initial begin
        logic [DW-1:0] v;
        int            c0;

        // Reset state, with every request valid so the readies are meaningful.
        reset = 1'b0; lk_valid = 1'b1; pb_valid = 1'b1; wr_valid = 1'b1;
        lk_set = '0; pb_set = '0; wr_set = 7'd1; wr_wayOH = 8'hFF; wr_data = 20'hFFFFF;
        do_preload = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        do_preload = 1'b0;
        chk("rst_done", DW'(init_done), DW'(0));
        chk("rst_rdy", DW'({lk_ready, pb_ready, wr_ready}), DW'(0));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_rsp_src", DW'(rsp_src), DW'(0));
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_wen", DW'(arr_w_en), DW'(0));

        // Reset pulse at sweep cycle 50; the array is preloaded again meanwhile.
        reset = 1'b1;
        sweep(50);
        reset = 1'b0;
        do_preload = 1'b1;
        #1;
        chk("mid_rst_wen", DW'(arr_w_en), DW'(0));
        chk("mid_rst_done", DW'(init_done), DW'(0));
        @(posedge clock); #1;
        do_preload = 1'b0;
        reset = 1'b1;
        c0 = wr_count;

        // Full sweep from set 0.
        sweep(SETS);
        lk_valid = 1'b0; pb_valid = 1'b0; wr_valid = 1'b0;
        #2;
        chk("done_at_128", DW'(init_done), DW'(1));
        chk("sweep_writes", DW'(wr_count - c0), DW'(SETS));
        v = '0;
        for (int s = 0; s < SETS; s++) v |= mem[s];
        chk("sweep_zero", v, '0);
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) ref_mem[s][w] = '0;
        @(posedge clock); #1;

        // Fill set 5 with way i = i+1, then look it up.
        for (int w = 0; w < WAYS; w++) begin
            wr_valid = 1'b1; wr_set = 7'h05; wr_wayOH = WAYS'(1 << w); wr_data = TAG_W'(w + 1);
            step();
        end
        wr_valid = 1'b0; lk_valid = 1'b1; lk_set = 7'h05;
        step();
        for (int w = 0; w < WAYS; w++) v[w*TAG_W +: TAG_W] = TAG_W'(w + 1);
        chk("single_read", rsp_data, v);

        // Write port lanes.
        lk_valid = 1'b0; wr_valid = 1'b1; wr_set = 7'd9; wr_wayOH = 8'h81; wr_data = 20'h12345;
        step();

        // Contention: lookup, probe, lookup, probe.
        wr_valid = 1'b0; lk_valid = 1'b1; pb_valid = 1'b1; lk_set = 7'd1; pb_set = 7'd2;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("contend_src", DW'(rsp_src), DW'(k % 2));
        end
        pb_valid = 1'b0;

        // Same-cycle bypass, then a write to another set.
        lk_valid = 1'b1; lk_set = 7'd3;
        wr_valid = 1'b1; wr_set = 7'd3; wr_wayOH = 8'b0000_0100; wr_data = 20'hABCDE;
        step();
        v = '0;
        v[2*TAG_W +: TAG_W] = 20'hABCDE;
        chk("bypass_hit", rsp_data, v);
        lk_set = 7'd6; wr_set = 7'd4;
        step();
        chk("bypass_miss", rsp_data, '0);

        // Random traffic on a few sets so collisions are frequent.
        for (int n = 0; n < 400; n++) begin
            lk_valid = 1'($urandom_range(0, 1));
            pb_valid = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            lk_set   = IDX_W'($urandom_range(0, 5));
            pb_set   = IDX_W'($urandom_range(0, 5));
            wr_set   = IDX_W'($urandom_range(0, 5));
            wr_wayOH = WAYS'($urandom_range(1, 255));
            wr_data  = TAG_W'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
